// File: rtl/lfsr_random_gen.sv
// rtl/lfsr_random_gen.sv - Fibonacci LFSR random source with scaled request/valid draws
// Optional feature: define RANDGEN_REJECT_EN for rejection sampling of draws against MAX_FIELD.
module lfsr_random_gen #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = 4'b1001,
  parameter logic [WIDTH-1:0] SEED      = 4'b0001,
  parameter int               OUT_BITS  = 4,
  parameter int               OUT_SHIFT = 4,
  parameter int               MIN_VAL   = 15,
  parameter int               VAL_W     = 8,
  parameter int               MAX_FIELD = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [VAL_W-1:0] value,
  output logic [WIDTH-1:0] state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]          r_fsm;
  logic [WIDTH-1:0]    r_state;
  logic                r_valid;
  logic [VAL_W-1:0]    r_value;

  logic                w_fb;
  logic [WIDTH-1:0]    w_step;
  logic [OUT_BITS-1:0] w_field;
  logic [VAL_W-1:0]    w_draw;
  logic                w_accept;
  logic                w_advance;

  assign w_fb      = ^(r_state & TAPS);
  assign w_step    = {w_fb, r_state[WIDTH-1:1]};
  assign w_field   = r_state[OUT_BITS-1:0];
  assign w_draw    = (VAL_W'(w_field) << OUT_SHIFT) + VAL_W'(MIN_VAL);
  // Retries must consume fresh state, so WAIT steps even with en low.
  assign w_advance = en | (r_fsm == S_WAIT);

`ifdef RANDGEN_REJECT_EN
  assign w_accept = (int'(w_field) <= MAX_FIELD);
  assign busy     = (r_fsm == S_WAIT);
`else
  logic w_unused_max;
  assign w_unused_max = (MAX_FIELD != 0);
  assign w_accept     = 1'b1;
  assign busy         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (seed_in == '0) ? SEED : seed_in;
    end else if (r_state == '0) begin
      r_state <= SEED;
    end else if (w_advance) begin
      r_state <= w_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm   <= S_IDLE;
      r_valid <= 1'b0;
      r_value <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (req) begin
            if (w_accept) begin
              r_value <= w_draw;
              r_valid <= 1'b1;
            end else begin
              r_fsm <= S_WAIT;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_value <= w_draw;
            r_valid <= 1'b1;
            r_fsm   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign valid = r_valid;
  assign value = r_value;
  assign state = r_state;

endmodule
